// File: rtl/cp_recovery_pkg.sv
// Shared types and helpers for the checkpoint recovery controller.
// Checkpoint count and branch lanes default from `NUM_CHECKPOINTS and
// `NUM_BRANCHES_RESOLVED when those macros are not supplied by the build.
// Optional feature macro used by the top level: RECOVERY_STATS_EN.
`ifndef NUM_CHECKPOINTS
`define NUM_CHECKPOINTS 8
`endif
`ifndef NUM_BRANCHES_RESOLVED
`define NUM_BRANCHES_RESOLVED 2
`endif

package cp_recovery_pkg;

    // Checkpoint slot count; must be a power of two so id arithmetic wraps for free.
    localparam int NUM_CP = `NUM_CHECKPOINTS;
    localparam int NUM_BR = `NUM_BRANCHES_RESOLVED;
    localparam int CP_W   = $clog2(NUM_CP);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RECALL   = 2'd1,
        FLUSH    = 2'd2,
        REDIRECT = 2'd3
    } rec_state_t;

    // Age relative to the oldest live checkpoint; smaller is older. Wraps mod NUM_CP.
    function automatic logic [CP_W-1:0] cp_age(input logic [CP_W-1:0] id,
                                               input logic [CP_W-1:0] back);
        return id - back;
    endfunction

endpackage

// File: rtl/oldest_branch_select.sv
// Combinational min-age reducer over the resolved-branch lanes. Picks the
// oldest mispredicted branch; on equal age the lowest lane index wins.
module oldest_branch_select
    import cp_recovery_pkg::*;
#(
    parameter int NBR = NUM_BR,
    localparam int IDX_W = (NBR > 1) ? $clog2(NBR) : 1
) (
    input  logic [NBR-1:0]            br_valid,
    input  logic [NBR-1:0]            br_mispredict,
    input  logic [NBR-1:0][CP_W-1:0]  br_cp_id,
    input  logic [NBR-1:0][31:0]      br_target,
    input  logic [CP_W-1:0]           cp_back,
    output logic                      found,
    output logic [IDX_W-1:0]          win_idx,
    output logic [CP_W-1:0]           win_id,
    output logic [31:0]               win_pc,
    output logic [CP_W-1:0]           win_age
);

    // Linear scan; strict less-than keeps the earlier lane on an age tie.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        win_id  = '0;
        win_pc  = '0;
        win_age = '0;
        for (int i = 0; i < NBR; i++) begin
            if (br_valid[i] && br_mispredict[i]) begin
                if (!found || (cp_age(br_cp_id[i], cp_back) < win_age)) begin
                    found   = 1'b1;
                    win_idx = IDX_W'(i);
                    win_id  = br_cp_id[i];
                    win_pc  = br_target[i];
                    win_age = cp_age(br_cp_id[i], cp_back);
                end
            end
        end
    end

endmodule

// File: rtl/checkpoint_recovery_ctrl.sv
// Branch-mispredict recovery sequencer: recall -> flush -> fetch redirect.
// Validates correct checkpoints combinationally, restarts on an older
// mispredict, and exposes its FSM state on dbg_state.
// Optional feature: define RECOVERY_STATS_EN to add mispredict_count and
// recovery_cycles saturating counters.
// Handshake: the redirect transfers on a cycle where redirect_valid and
// redirect_ready are both 1; redirect_valid and redirect_pc stay stable
// until then, unless an older mispredict restarts the sequence.
module checkpoint_recovery_ctrl
    import cp_recovery_pkg::*;
#(
    parameter int NBR          = NUM_BR,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NBR-1:0]            br_valid,
    input  logic [NBR-1:0]            br_mispredict,
    input  logic [NBR-1:0][CP_W-1:0]  br_cp_id,
    input  logic [NBR-1:0][31:0]      br_target,
    input  logic [CP_W-1:0]           cp_back,
    output logic [NBR-1:0]            validate,
    output logic [NBR-1:0][CP_W-1:0]  validated_id,
    output logic                      recall_checkpoint,
    output logic [CP_W-1:0]           recall_id,
    output logic                      flush,
    output logic                      recovery_busy,
    output logic                      redirect_valid,
    output logic [31:0]               redirect_pc,
    input  logic                      redirect_ready,
`ifdef RECOVERY_STATS_EN
    output logic [31:0]               mispredict_count,
    output logic [31:0]               recovery_cycles,
`endif
    output rec_state_t                dbg_state
);

    localparam int IDX_W = (NBR > 1) ? $clog2(NBR) : 1;
    localparam int CNT_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

    rec_state_t        state, next_state;
    logic [CP_W-1:0]   act_id, next_act_id;
    logic [31:0]       act_pc, next_act_pc;
    logic [CNT_W-1:0]  cnt, next_cnt;

    logic              found;
    logic [IDX_W-1:0]  win_idx;
    logic [CP_W-1:0]   win_id;
    logic [31:0]       win_pc;
    logic [CP_W-1:0]   win_age;
    logic [CP_W-1:0]   act_age;
    logic              capture;

    oldest_branch_select #(.NBR(NBR)) u_sel (
        .br_valid      (br_valid),
        .br_mispredict (br_mispredict),
        .br_cp_id      (br_cp_id),
        .br_target     (br_target),
        .cp_back       (cp_back),
        .found         (found),
        .win_idx       (win_idx),
        .win_id        (win_id),
        .win_pc        (win_pc),
        .win_age       (win_age)
    );

    assign act_age      = cp_age(act_id, cp_back);
    assign capture      = found && ((state == IDLE) || (win_age < act_age));
    assign validated_id = br_cp_id;
    assign dbg_state    = state;

    // Validate correct branches unless they sit behind this cycle's winner
    // or behind the recovery in progress; the winning lane itself never validates.
    always_comb begin
        validate = '0;
        for (int i = 0; i < NBR; i++) begin
            validate[i] = br_valid[i] & ~br_mispredict[i] & ~reset;
            if (found && (cp_age(br_cp_id[i], cp_back) > win_age))
                validate[i] = 1'b0;
            if ((state != IDLE) && (cp_age(br_cp_id[i], cp_back) > act_age))
                validate[i] = 1'b0;
            if (found && (win_idx == IDX_W'(i)))
                validate[i] = 1'b0;
        end
    end

    // Next-state, flush counter and capture logic; an older mispredict overrides everything.
    always_comb begin
        next_state  = state;
        next_act_id = act_id;
        next_act_pc = act_pc;
        next_cnt    = cnt;
        case (state)
            IDLE: begin
                next_state = IDLE;
            end
            RECALL: begin
                next_cnt = CNT_W'(FLUSH_CYCLES);
                if (FLUSH_CYCLES == 0)
                    next_state = REDIRECT;
                else
                    next_state = FLUSH;
            end
            FLUSH: begin
                next_cnt = cnt - 1'b1;
                if (cnt == CNT_W'(1))
                    next_state = REDIRECT;
            end
            REDIRECT: begin
                if (redirect_valid && redirect_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (capture) begin
            next_state  = RECALL;
            next_act_id = win_id;
            next_act_pc = win_pc;
        end
    end

    // State, capture registers and counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            act_id <= '0;
            act_pc <= '0;
            cnt    <= '0;
        end else begin
            state  <= next_state;
            act_id <= next_act_id;
            act_pc <= next_act_pc;
            cnt    <= next_cnt;
        end
    end

    // Registered outputs decoded from the next state so they align with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            recall_checkpoint <= 1'b0;
            recall_id         <= '0;
            flush             <= 1'b0;
            recovery_busy     <= 1'b0;
            redirect_valid    <= 1'b0;
            redirect_pc       <= '0;
        end else begin
            recall_checkpoint <= (next_state == RECALL);
            recall_id         <= next_act_id;
            flush             <= (next_state == FLUSH);
            recovery_busy     <= (next_state != IDLE);
            redirect_valid    <= (next_state == REDIRECT);
            redirect_pc       <= next_act_pc;
        end
    end

`ifdef RECOVERY_STATS_EN
    // Saturating recovery statistics; restarts count as new RECALL entries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mispredict_count <= '0;
            recovery_cycles  <= '0;
        end else begin
            if ((next_state == RECALL) && (mispredict_count != '1))
                mispredict_count <= mispredict_count + 32'd1;
            if (recovery_busy && (recovery_cycles != '1))
                recovery_cycles <= recovery_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_checkpoint_recovery_ctrl.sv
// Directed bench for checkpoint_recovery_ctrl (NCP=8, NBR=2, FLUSH_CYCLES=2).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_checkpoint_recovery_ctrl;
    import cp_recovery_pkg::*;

    localparam int NBR = 2;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NBR-1:0]            br_valid;
    logic [NBR-1:0]            br_mispredict;
    logic [NBR-1:0][CP_W-1:0]  br_cp_id;
    logic [NBR-1:0][31:0]      br_target;
    logic [CP_W-1:0]           cp_back;
    logic [NBR-1:0]            validate;
    logic [NBR-1:0][CP_W-1:0]  validated_id;
    logic                      recall_checkpoint;
    logic [CP_W-1:0]           recall_id;
    logic                      flush;
    logic                      recovery_busy;
    logic                      redirect_valid;
    logic [31:0]               redirect_pc;
    logic                      redirect_ready;
`ifdef RECOVERY_STATS_EN
    logic [31:0]               mispredict_count;
    logic [31:0]               recovery_cycles;
`endif
    rec_state_t                dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    checkpoint_recovery_ctrl #(.NBR(NBR), .FLUSH_CYCLES(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .br_valid          (br_valid),
        .br_mispredict     (br_mispredict),
        .br_cp_id          (br_cp_id),
        .br_target         (br_target),
        .cp_back           (cp_back),
        .validate          (validate),
        .validated_id      (validated_id),
        .recall_checkpoint (recall_checkpoint),
        .recall_id         (recall_id),
        .flush             (flush),
        .recovery_busy     (recovery_busy),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .redirect_ready    (redirect_ready),
`ifdef RECOVERY_STATS_EN
        .mispredict_count  (mispredict_count),
        .recovery_cycles   (recovery_cycles),
`endif
        .dbg_state         (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_br();
        br_valid      = '0;
        br_mispredict = '0;
        br_cp_id      = '0;
        br_target     = '0;
    endtask

    task automatic drive_br(input int lane, input logic mis,
                            input logic [CP_W-1:0] id, input logic [31:0] tgt);
        br_valid[lane]      = 1'b1;
        br_mispredict[lane] = mis;
        br_cp_id[lane]      = id;
        br_target[lane]     = tgt;
    endtask

    // Wait (bounded) for the redirect, check its pc, then handshake it.
    task automatic finish_recovery(input logic [31:0] exp_pc);
        int k = 0;
        while (!redirect_valid && k < 20) begin
            tick();
            k++;
        end
        n_cmp++;
        if (redirect_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL redirect_timeout: got redirect_valid=%b expected 1", redirect_valid);
        end
        n_cmp++;
        if (redirect_pc !== exp_pc) begin
            n_bad++;
            $display("FAIL finish_redirect_pc: got %h expected %h", redirect_pc, exp_pc);
        end
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        n_cmp++;
        if (recovery_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL finish_idle_busy: got %b expected 0", recovery_busy);
        end
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        redirect_ready = 1'b0;
        cp_back        = '0;
        clear_br();
        drive_br(0, 1'b0, 3'd1, 32'h0);
        #1;
        n_cmp++;
        if (validate !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_validate_mask: got %b expected 00", validate);
        end
        repeat (2) tick();
        n_cmp++;
        if ({recall_checkpoint, flush, recovery_busy, redirect_valid} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {recall_checkpoint, flush, recovery_busy, redirect_valid});
        end
        n_cmp++;
        if (recall_id !== 3'd0 || redirect_pc !== 32'h0 || dbg_state !== IDLE) begin
            n_bad++;
            $display("FAIL reset_values: got id=%h pc=%h st=%0d expected 0 0 0",
                     recall_id, redirect_pc, dbg_state);
        end
        clear_br();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_validate_correct();
        logic [NBR-1:0][CP_W-1:0] exp_ids;
        exp_ids[0] = 3'd2;
        exp_ids[1] = 3'd3;
        cp_back = 3'd0;
        clear_br();
        drive_br(0, 1'b0, 3'd2, 32'h0);
        drive_br(1, 1'b0, 3'd3, 32'h0);
        #1;
        n_cmp++;
        if (validate !== 2'b11) begin
            n_bad++;
            $display("FAIL validate_both: got %b expected 11", validate);
        end
        n_cmp++;
        if (validated_id !== exp_ids) begin
            n_bad++;
            $display("FAIL validated_id: got %h expected %h", validated_id, exp_ids);
        end
        tick();
        clear_br();
        n_cmp++;
        if (recall_checkpoint !== 1'b0 || recovery_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL validate_no_recall: got rc=%b busy=%b expected 0 0",
                     recall_checkpoint, recovery_busy);
        end
    endtask

    task automatic test_single_mispredict();
        cp_back = 3'd0;
        clear_br();
        drive_br(0, 1'b1, 3'd4, 32'h100);
        #1;
        n_cmp++;
        if (validate !== 2'b00) begin
            n_bad++;
            $display("FAIL mispredict_not_validated: got %b expected 00", validate);
        end
        tick();
        clear_br();
        n_cmp++;
        if (recall_checkpoint !== 1'b1 || recall_id !== 3'd4 || recovery_busy !== 1'b1 || flush !== 1'b0) begin
            n_bad++;
            $display("FAIL single_recall: got rc=%b id=%0d busy=%b fl=%b expected 1 4 1 0",
                     recall_checkpoint, recall_id, recovery_busy, flush);
        end
        tick();
        n_cmp++;
        if (flush !== 1'b1 || recall_checkpoint !== 1'b0) begin
            n_bad++;
            $display("FAIL single_flush1: got fl=%b rc=%b expected 1 0", flush, recall_checkpoint);
        end
        tick();
        n_cmp++;
        if (flush !== 1'b1) begin
            n_bad++;
            $display("FAIL single_flush2: got %b expected 1", flush);
        end
        tick();
        n_cmp++;
        if (flush !== 1'b0 || redirect_valid !== 1'b1 || redirect_pc !== 32'h100) begin
            n_bad++;
            $display("FAIL single_redirect: got fl=%b rv=%b pc=%h expected 0 1 100",
                     flush, redirect_valid, redirect_pc);
        end
        tick();
        n_cmp++;
        if (redirect_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL single_redirect_hold: got %b expected 1", redirect_valid);
        end
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        n_cmp++;
        if (redirect_valid !== 1'b0 || recovery_busy !== 1'b0 || dbg_state !== IDLE) begin
            n_bad++;
            $display("FAIL single_idle: got rv=%b busy=%b st=%0d expected 0 0 0",
                     redirect_valid, recovery_busy, dbg_state);
        end
    endtask

    task automatic test_oldest_select();
        cp_back = 3'd6;
        clear_br();
        drive_br(0, 1'b1, 3'd1, 32'h200);
        drive_br(1, 1'b1, 3'd7, 32'h300);
        tick();
        clear_br();
        n_cmp++;
        if (recall_checkpoint !== 1'b1 || recall_id !== 3'd7) begin
            n_bad++;
            $display("FAIL oldest_recall_id: got rc=%b id=%0d expected 1 7", recall_checkpoint, recall_id);
        end
        // act=7 (age 1): id 6 (age 0) validates, id 0 (age 2) is masked
        drive_br(0, 1'b0, 3'd6, 32'h0);
        drive_br(1, 1'b0, 3'd0, 32'h0);
        #1;
        n_cmp++;
        if (validate !== 2'b01) begin
            n_bad++;
            $display("FAIL busy_validate_mask: got %b expected 01", validate);
        end
        clear_br();
        finish_recovery(32'h300);
        // same cycle: correct id 2 (age 4) behind mispredict id 7 (age 1)
        drive_br(0, 1'b0, 3'd2, 32'h0);
        drive_br(1, 1'b1, 3'd7, 32'h300);
        #1;
        n_cmp++;
        if (validate !== 2'b00) begin
            n_bad++;
            $display("FAIL winner_validate_mask: got %b expected 00", validate);
        end
        tick();
        clear_br();
        n_cmp++;
        if (recall_id !== 3'd7) begin
            n_bad++;
            $display("FAIL wrap_recall_id: got %0d expected 7", recall_id);
        end
        finish_recovery(32'h300);
        cp_back = 3'd0;
    endtask

    task automatic test_restart_in_flush();
        cp_back = 3'd0;
        clear_br();
        drive_br(0, 1'b1, 3'd5, 32'h500);
        tick();
        clear_br();
        tick();
        n_cmp++;
        if (flush !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_flush_start: got %b expected 1", flush);
        end
        drive_br(0, 1'b1, 3'd6, 32'h600);
        tick();
        clear_br();
        n_cmp++;
        if (flush !== 1'b1 || recall_checkpoint !== 1'b0) begin
            n_bad++;
            $display("FAIL younger_dropped: got fl=%b rc=%b expected 1 0", flush, recall_checkpoint);
        end
        drive_br(0, 1'b1, 3'd3, 32'h300);
        tick();
        clear_br();
        n_cmp++;
        if (recall_checkpoint !== 1'b1 || recall_id !== 3'd3 || flush !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_recall: got rc=%b id=%0d fl=%b expected 1 3 0",
                     recall_checkpoint, recall_id, flush);
        end
        tick();
        tick();
        n_cmp++;
        if (flush !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_counter: got %b expected 1", flush);
        end
        tick();
        n_cmp++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h300) begin
            n_bad++;
            $display("FAIL restart_redirect: got rv=%b pc=%h expected 1 300", redirect_valid, redirect_pc);
        end
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
    endtask

    task automatic test_restart_over_redirect();
        cp_back = 3'd0;
        clear_br();
        drive_br(0, 1'b1, 3'd5, 32'h500);
        tick();
        clear_br();
        repeat (3) tick();
        n_cmp++;
        if (redirect_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL over_redirect_reach: got %b expected 1", redirect_valid);
        end
        redirect_ready = 1'b1;
        drive_br(1, 1'b1, 3'd1, 32'h111);
        tick();
        redirect_ready = 1'b0;
        clear_br();
        n_cmp++;
        if (redirect_valid !== 1'b0 || recall_checkpoint !== 1'b1 || recall_id !== 3'd1) begin
            n_bad++;
            $display("FAIL restart_over_redirect: got rv=%b rc=%b id=%0d expected 0 1 1",
                     redirect_valid, recall_checkpoint, recall_id);
        end
        finish_recovery(32'h111);
    endtask

    task automatic test_redirect_hold_and_reset();
        cp_back = 3'd0;
        clear_br();
        drive_br(0, 1'b1, 3'd2, 32'h444);
        tick();
        clear_br();
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (redirect_valid !== 1'b1 || redirect_pc !== 32'h444) begin
                n_bad++;
                $display("FAIL redirect_hold[%0d]: got rv=%b pc=%h expected 1 444",
                         i, redirect_valid, redirect_pc);
            end
            tick();
        end
        reset = 1'b1;
        drive_br(0, 1'b0, 3'd1, 32'h0);
        #1;
        n_cmp++;
        if ({recall_checkpoint, flush, recovery_busy, redirect_valid, validate} !== 6'b0) begin
            n_bad++;
            $display("FAIL async_reset_flags: got %b expected 000000",
                     {recall_checkpoint, flush, recovery_busy, redirect_valid, validate});
        end
        n_cmp++;
        if (recall_id !== 3'd0 || redirect_pc !== 32'h0 || dbg_state !== IDLE) begin
            n_bad++;
            $display("FAIL async_reset_values: got id=%h pc=%h st=%0d expected 0 0 0",
                     recall_id, redirect_pc, dbg_state);
        end
        reset = 1'b0;
        clear_br();
        tick();
    endtask

`ifdef RECOVERY_STATS_EN
    task automatic test_stats();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (mispredict_count !== 32'd0 || recovery_cycles !== 32'd0) begin
            n_bad++;
            $display("FAIL stats_reset: got %0d %0d expected 0 0", mispredict_count, recovery_cycles);
        end
        cp_back = 3'd0;
        // 5 busy cycles
        drive_br(0, 1'b1, 3'd3, 32'h10);
        tick();
        clear_br();
        repeat (4) tick();
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        // 7 busy cycles
        drive_br(1, 1'b1, 3'd4, 32'h20);
        tick();
        clear_br();
        repeat (6) tick();
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        n_cmp++;
        if (mispredict_count !== 32'd2) begin
            n_bad++;
            $display("FAIL stats_mispredicts: got %0d expected 2", mispredict_count);
        end
        n_cmp++;
        if (recovery_cycles !== 32'd12) begin
            n_bad++;
            $display("FAIL stats_cycles: got %0d expected 12", recovery_cycles);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_validate_correct();
        test_single_mispredict();
        test_oldest_select();
        test_restart_in_flush();
        test_restart_over_redirect();
        test_redirect_hold_and_reset();
`ifdef RECOVERY_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
